// File: rtl/nco_multichannel.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | nco_multichannel: time-multiplexed DDS, CHANNELS phase accumulators     |
// | sharing an interpolated sine LUT pair, with a per-period channel mix.   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+

module nco_sine_rom #(
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int SAMPLE_WIDTH   = 12
) (
  input  logic                      clk,
  input  logic [LUT_ADDR_WIDTH-1:0] addr_i,
  output logic [SAMPLE_WIDTH-1:0]   data_o
);
  localparam int DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam int MID   = 1 << (SAMPLE_WIDTH - 1);

  // Table contents are computed at elaboration so the block carries no data file.
  function automatic logic [SAMPLE_WIDTH-1:0] sine_entry(input int idx);
    real ph;
    real v;
    ph = 6.283185307179586 * real'(idx) / real'(DEPTH);
    v  = real'(MID) + real'(MID - 1) * $sin(ph);
    return SAMPLE_WIDTH'($rtoi(v + 0.5));
  endfunction

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign mem[i] = sine_entry(i);
  end

  always_ff @(posedge clk) begin
    data_o <= mem[addr_i];
  end
endmodule

module nco_multichannel #(
  parameter int CHANNELS       = 4,
  parameter int PHASE_WIDTH    = 24,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int INTERP_BITS    = 6,
  parameter int SAMPLE_WIDTH   = 12,
  parameter int SAMPLE_DIV     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic                    cfg_op,
  input  logic [7:0]              cfg_channel,
  input  logic [PHASE_WIDTH-1:0]  cfg_data,
  output logic                    out_valid,
  output logic [7:0]              out_channel,
  output logic [SAMPLE_WIDTH-1:0] out_sample,
  output logic                    mix_valid,
  output logic [SAMPLE_WIDTH-1:0] mix_out
);
  localparam int FRAC_W = PHASE_WIDTH - LUT_ADDR_WIDTH;
  localparam int CIW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LOG_CH = $clog2(CHANNELS);
  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam int IW     = SAMPLE_WIDTH + INTERP_BITS + 1;
  localparam int ACC_W  = SAMPLE_WIDTH + 1 + LOG_CH;
  localparam logic [SAMPLE_WIDTH-1:0] MID = SAMPLE_WIDTH'(1 << (SAMPLE_WIDTH - 1));

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   scan_act_q, scan_act_d;
  logic [CIW-1:0]         scan_idx_q, scan_idx_d;
  logic [PHASE_WIDTH-1:0] phase_q [CHANNELS];
  logic [PHASE_WIDTH-1:0] phase_d [CHANNELS];
  logic [PHASE_WIDTH-1:0] freq_q  [CHANNELS];
  logic [PHASE_WIDTH-1:0] freq_d  [CHANNELS];

  logic                      tick;
  logic                      cfg_hit;
  logic [CIW-1:0]            cfg_idx;
  logic [LUT_ADDR_WIDTH-1:0] rd_addr, rd_addr_n;
  logic [INTERP_BITS-1:0]    rd_frac;

  assign tick    = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
  assign cfg_hit = ({1'b0, cfg_channel} < 9'(CHANNELS));
  assign cfg_idx = cfg_channel[CIW-1:0];

  assign rd_addr   = phase_q[scan_idx_q][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
  assign rd_addr_n = rd_addr + 1'b1;
  assign rd_frac   = phase_q[scan_idx_q][FRAC_W-1 -: INTERP_BITS];

  always_comb begin
    scan_act_d = scan_act_q;
    scan_idx_d = scan_idx_q;
    if (tick) begin
      scan_act_d = 1'b1;
      scan_idx_d = '0;
    end else if (scan_act_q) begin
      if (scan_idx_q == CIW'(CHANNELS - 1)) scan_act_d = 1'b0;
      else                                  scan_idx_d = scan_idx_q + 1'b1;
    end
  end

  // A phase write is applied after accumulation so it overrides the read-cycle update.
  always_comb begin
    phase_d = phase_q;
    freq_d  = freq_q;
    if (scan_act_q) phase_d[scan_idx_q] = phase_q[scan_idx_q] + freq_q[scan_idx_q];
    if (cfg_valid && cfg_hit) begin
      if (cfg_op) phase_d[cfg_idx] = cfg_data;
      else        freq_d[cfg_idx]  = cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      scan_act_q <= 1'b0;
      scan_idx_q <= '0;
      phase_q    <= '{default: '0};
      freq_q     <= '{default: '0};
    end else begin
      cnt_q      <= cnt_d;
      scan_act_q <= scan_act_d;
      scan_idx_q <= scan_idx_d;
      phase_q    <= phase_d;
      freq_q     <= freq_d;
    end
  end

  logic [SAMPLE_WIDTH-1:0] lut_a, lut_b;

  nco_sine_rom #(.LUT_ADDR_WIDTH(LUT_ADDR_WIDTH), .SAMPLE_WIDTH(SAMPLE_WIDTH)) sine_lut (
    .clk(clk), .addr_i(rd_addr), .data_o(lut_a)
  );
  nco_sine_rom #(.LUT_ADDR_WIDTH(LUT_ADDR_WIDTH), .SAMPLE_WIDTH(SAMPLE_WIDTH)) sine_lut_d (
    .clk(clk), .addr_i(rd_addr_n), .data_o(lut_b)
  );

  logic                    s1_valid_q, s2_valid_q;
  logic [CIW-1:0]          s1_ch_q, s2_ch_q;
  logic [INTERP_BITS-1:0]  s1_frac_q;
  logic [SAMPLE_WIDTH-1:0] s2_y_q, s2_y_d;

  logic signed [IW-1:0] ia, ib, ifr, iprod;
  always_comb begin
    ia     = $signed({{(IW-SAMPLE_WIDTH){1'b0}}, lut_a});
    ib     = $signed({{(IW-SAMPLE_WIDTH){1'b0}}, lut_b});
    ifr    = $signed({{(IW-INTERP_BITS){1'b0}}, s1_frac_q});
    iprod  = (ib - ia) * ifr;
    s2_y_d = SAMPLE_WIDTH'(ia + (iprod >>> INTERP_BITS));
  end

  logic signed [SAMPLE_WIDTH:0] dev;
  logic signed [ACC_W-1:0]      acc_q, acc_d, acc_avg;
  logic                         last_out;

  assign dev      = $signed({1'b0, s2_y_q}) - $signed({1'b0, MID});
  assign acc_d    = tick ? '0 : (s2_valid_q ? acc_q + ACC_W'(dev) : acc_q);
  assign acc_avg  = acc_q >>> LOG_CH;
  assign last_out = out_valid && (out_channel == 8'(CHANNELS - 1));

  always_ff @(posedge clk) begin
    s1_ch_q   <= scan_idx_q;
    s1_frac_q <= rd_frac;
    s2_ch_q   <= s1_ch_q;
    s2_y_q    <= s2_y_d;
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      acc_q       <= '0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_sample  <= MID;
      mix_valid   <= 1'b0;
      mix_out     <= MID;
    end else begin
      s1_valid_q <= scan_act_q;
      s2_valid_q <= s1_valid_q;
      acc_q      <= acc_d;
      out_valid  <= s2_valid_q;
      if (s2_valid_q) begin
        out_channel <= 8'(s2_ch_q);
        out_sample  <= s2_y_q;
      end
      mix_valid <= last_out;
      if (last_out) mix_out <= SAMPLE_WIDTH'(acc_avg + ACC_W'(MID));
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_nco_multichannel.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_nco_multichannel: directed self-checking bench for nco_multichannel. |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_nco_multichannel;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_op = 1'b0;
  logic [7:0]  cfg_channel = 8'd0;
  logic [23:0] cfg_data = 24'd0;
  logic        out_valid;
  logic [7:0]  out_channel;
  logic [11:0] out_sample;
  logic        mix_valid;
  logic [11:0] mix_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int waited = 0;

  always #5 clk = ~clk;

  nco_multichannel #(
    .CHANNELS(4), .PHASE_WIDTH(24), .LUT_ADDR_WIDTH(10),
    .INTERP_BITS(6), .SAMPLE_WIDTH(12), .SAMPLE_DIV(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_op(cfg_op),
    .cfg_channel(cfg_channel), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_channel(out_channel), .out_sample(out_sample),
    .mix_valid(mix_valid), .mix_out(mix_out)
  );

  // Reference sine table: round(2048 + 2047*sin(2*pi*i/1024)).
  function automatic int lut(input int i);
    real v;
    v = 2048.0 + 2047.0 * $sin(6.283185307179586 * real'(i % 1024) / 1024.0);
    return $rtoi(v + 0.5);
  endfunction

  function automatic int interp(input int a, input int b, input int f);
    return a + (((b - a) * f) >>> 6);
  endfunction

  function automatic int mixexp(input int e0, input int e1, input int e2, input int e3);
    int s;
    s = (e0 - 2048) + (e1 - 2048) + (e2 - 2048) + (e3 - 2048);
    return 2048 + (s >>> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input bit op, input int ch, input int d);
    cfg_valid   = 1'b1;
    cfg_op      = op;
    cfg_channel = 8'(ch);
    cfg_data    = 24'(d);
    @(posedge clk); #1;
    cfg_valid   = 1'b0;
  endtask

  // Waits for the next ch0 strobe, checks the four samples and the following mix strobe.
  task automatic period(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    waited = 0;
    @(negedge clk);
    while (!(out_valid === 1'b1 && out_channel === 8'd0) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_nomix_early"}, 32'(mix_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 32'd1);
      chk($sformatf("%s_chan%0d", tag, k), 32'(out_channel), 32'(k));
      chk($sformatf("%s_samp%0d", tag, k), 32'(out_sample), 32'(e[k]));
      @(negedge clk);
    end
    chk({tag, "_mixvalid"}, 32'(mix_valid), 32'd1);
    chk({tag, "_outidle"}, 32'(out_valid), 32'd0);
    chk({tag, "_mix"}, 32'(mix_out), 32'(mixexp(e0, e1, e2, e3)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_sample", 32'(out_sample), 32'h800);
    chk("rst_mix", 32'(mix_out), 32'h800);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_mixvalid", 32'(mix_valid), 32'd0);
    chk("rst_chan", 32'(out_channel), 32'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    period("idle1", lut(0), lut(0), lut(0), lut(0));
    chk("first_tick_delay", 32'(waited), 32'd19);
    period("idle2", lut(0), lut(0), lut(0), lut(0));
    chk("period_spacing", 32'(waited), 32'd11);

    // Integer step on ch0, full phase wrap after 1024 periods
    @(posedge clk); #1;
    cfg(1'b0, 0, 'h004000);
    for (int i = 0; i <= 1024; i++) period("step", lut(i), 2048, 2048, 2048);
    @(posedge clk); #1;
    cfg(1'b0, 0, 0);
    cfg(1'b1, 0, 0);

    // Half-step interpolation on ch1
    cfg(1'b0, 1, 'h002000);
    for (int i = 0; i < 8; i++)
      period("interp", 2048, (i % 2 == 0) ? lut(i / 2) : interp(lut(i / 2), lut(i / 2 + 1), 32), 2048, 2048);
    @(posedge clk); #1;
    cfg(1'b0, 1, 0);
    cfg(1'b1, 1, 0);

    // Negative tuning word wraps downward; then interpolate across the table end
    cfg(1'b0, 2, 'hFFC000);
    for (int i = 0; i < 3; i++) period("wrapneg", 2048, 2048, lut((1024 - i) % 1024), 2048);
    @(posedge clk); #1;
    cfg(1'b0, 2, 0);
    cfg(1'b1, 2, 'hFFE000);
    period("wrapint", 2048, 2048, interp(lut(1023), lut(0), 32), 2048);
    period("wrapint", 2048, 2048, interp(lut(1023), lut(0), 32), 2048);
    @(posedge clk); #1;
    cfg(1'b1, 2, 0);

    // Frequency write colliding with ch0 read cycle
    cfg(1'b0, 0, 'h004000);
    period("coll0", lut(0), 2048, 2048, 2048);
    repeat (9) @(posedge clk); #1;
    cfg(1'b0, 0, 'h008000);
    period("coll1", lut(1), 2048, 2048, 2048);
    period("coll2", lut(2), 2048, 2048, 2048);
    period("coll3", lut(4), 2048, 2048, 2048);

    // Out-of-range channel writes are ignored
    @(posedge clk); #1;
    cfg(1'b0, 7, 'h004000);
    cfg(1'b1, 7, 'h123456);
    period("ignore1", lut(6), 2048, 2048, 2048);
    period("ignore2", lut(8), 2048, 2048, 2048);

    // Phase write in ch3 read cycle wins over accumulation
    @(posedge clk); #1;
    cfg(1'b0, 3, 'h004000);
    repeat (10) @(posedge clk); #1;
    cfg(1'b1, 3, 'h100000);
    period("phwin1", lut(12), 2048, 2048, lut(64));
    period("phwin2", lut(14), 2048, 2048, lut(65));

    // Two anti-phase channels mix to near midscale
    @(posedge clk); #1;
    cfg(1'b1, 0, 0);
    cfg(1'b0, 0, 'h004000);
    cfg(1'b1, 1, 'h800000);
    cfg(1'b0, 1, 'h004000);
    cfg(1'b0, 2, 0);
    cfg(1'b1, 2, 0);
    cfg(1'b0, 3, 0);
    cfg(1'b1, 3, 0);
    for (int i = 0; i < 4; i++) begin
      period("mix", lut(i), lut(512 + i), 2048, 2048);
      chk("mix_range", 32'((mix_out >= 12'd2047) && (mix_out <= 12'd2049)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
